updown_cnt_seq_ctrl: RTL and testbench

// - Command-driven sequencer for one W-bit loadable up/down counter (ports en/udbar/ld/ld_val/cnt).
// - Accepts {op,arg} commands over valid/ready and turns each into a timed series of counter-control cycles.
// - Ops: load value, count up N steps, count down N steps, hold N cycles.
// - Reports completion (done) and counter wrap-around.
// - Sits between a host/test FSM and the counter; it is the only driver of the counter control pins.

---
 rtl/updown_cnt_seq_ctrl.sv | 94 +++++++++
 tb/tb_updown_cnt_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/updown_cnt_seq_ctrl.sv
// updown_cnt_seq_ctrl: turns {op,arg} commands into timed load/enable/direction cycles for an up/down counter.
// Optional abort input enabled by defining SEQ_ABORT_EN.
module updown_cnt_seq_ctrl #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_arg,
  input  logic [W-1:0]  cnt_i,
  output logic          ctr_en,
  output logic          ctr_udbar,
  output logic          ctr_ld,
  output logic [W-1:0]  ctr_ld_val,
  output logic          busy,
  output logic          done,
  output logic          wrap
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_DOWN = 2'd2;
  localparam logic [1:0] OP_HOLD = 2'd3;

  if (CW < W) begin : g_bad_cw
    $error("updown_cnt_seq_ctrl: CW must be >= W");
  end

  logic [1:0]    r_state;
  logic [CW-1:0] r_step;
  logic [W-1:0]  r_ldv;
  logic          r_dn;
  logic          r_done;
  logic          r_wrap;
  logic          w_abort;
  logic          w_end;

`ifdef SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // the step counter walks N..1, so the last active cycle is when it reads 1
  assign w_end = w_abort | (r_step == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_ldv   <= '0;
      r_dn    <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= ctr_en & (ctr_udbar ? &cnt_i : ~|cnt_i);
      if (r_state == S_IDLE) begin
        if (cmd_valid) begin
          r_step <= cmd_arg;
          r_ldv  <= cmd_arg[W-1:0];
          r_dn   <= cmd_op == OP_DOWN;
          r_state <= cmd_op == OP_LOAD ? S_LOAD :
                     cmd_arg == '0     ? S_IDLE :
                     cmd_op == OP_HOLD ? S_HOLD : S_RUN;
          r_done <= cmd_op != OP_LOAD && cmd_arg == '0;
        end
      end else if (r_state == S_LOAD || w_end) begin
        r_state <= S_IDLE;
        r_step  <= '0;
        r_done  <= 1'b1;
      end else begin
        r_step <= r_step - CW'(1);
      end
    end
  end

  assign cmd_ready  = r_state == S_IDLE;
  assign busy       = ~cmd_ready;
  assign ctr_en     = r_state == S_RUN;
  assign ctr_udbar  = ~(ctr_en & r_dn);
  assign ctr_ld     = r_state == S_LOAD;
  assign ctr_ld_val = ctr_ld ? r_ldv : '0;
  assign done       = r_done;
  assign wrap       = r_wrap;
endmodule

// File: tb/tb_updown_cnt_seq_ctrl.sv
// tb_updown_cnt_seq_ctrl: command table plus corner sequences against a behavioural counter.
module tb_updown_cnt_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [CW-1:0] cmd_arg = '0;
  logic [W-1:0]  cnt = '0;
  logic          ctr_en, ctr_udbar, ctr_ld, busy, done, wrap;
  logic [W-1:0]  ctr_ld_val;
`ifdef SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  typedef struct {
    logic [1:0]    op;
    logic [CW-1:0] arg;
    int            lat, ens, lds, busys, wraps;
    logic [W-1:0]  cnt;
  } vec_t;

  vec_t tbl[10];
  vec_t q[$];
  int   checks = 0;
  int   errors = 0;

  updown_cnt_seq_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
`ifdef SEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cnt_i(cnt), .ctr_en(ctr_en), .ctr_udbar(ctr_udbar), .ctr_ld(ctr_ld),
    .ctr_ld_val(ctr_ld_val), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ctr_ld) cnt <= ctr_ld_val;
    else if (ctr_en) cnt <= ctr_udbar ? cnt + 1'b1 : cnt - 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int ens = 0, lds = 0, busys = 0, wraps = 0, lat = 0, bad = 0;
    logic [W-1:0] lv;
    vec_t e;
    lv = v.arg[W-1:0];
    q.push_back(v);
    @(negedge clk);
    chk("ready_before", cmd_ready, 1);
    chk("done_single", done, 0);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_arg = v.arg;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      ens += int'(ctr_en); lds += int'(ctr_ld); busys += int'(busy); wraps += int'(wrap);
      if (ctr_en && ctr_udbar != (v.op != 2'd2)) bad++;
      if (!ctr_en && !ctr_udbar) bad++;
      if (ctr_ld ? ctr_ld_val != lv : ctr_ld_val != '0) bad++;
      if (done) begin
        lat = k;
        break;
      end
    end
    e = q.pop_front();
    chk("latency", lat, e.lat);
    chk("en_cycles", ens, e.ens);
    chk("ld_cycles", lds, e.lds);
    chk("busy_cycles", busys, e.busys);
    chk("wraps", wraps, e.wraps);
    chk("cnt_at_done", int'(cnt), int'(e.cnt));
    chk("ready_at_done", cmd_ready, 1);
    chk("protocol", bad, 0);
  endtask

  initial begin
    int lat1, lat2, dn, seen;
    vec_t v;
    tbl[0] = '{2'd0, 8'd9,    2, 0,  1, 1,  0, 4'd9};
    tbl[1] = '{2'd1, 8'd3,    4, 3,  0, 3,  0, 4'd12};
    tbl[2] = '{2'd0, 8'd2,    2, 0,  1, 1,  0, 4'd2};
    tbl[3] = '{2'd2, 8'd5,    6, 5,  0, 5,  1, 4'd13};
    tbl[4] = '{2'd1, 8'd0,    1, 0,  0, 0,  0, 4'd13};
    tbl[5] = '{2'd3, 8'd0,    1, 0,  0, 0,  0, 4'd13};
    tbl[6] = '{2'd3, 8'd4,    5, 0,  0, 4,  0, 4'd13};
    tbl[7] = '{2'd0, 8'hF5,   2, 0,  1, 1,  0, 4'd5};
    tbl[8] = '{2'd1, 8'd11,  12, 11, 0, 11, 1, 4'd0};
    tbl[9] = '{2'd2, 8'd1,    2, 1,  0, 1,  1, 4'd15};

    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_en", ctr_en, 0);
    chk("rst_udbar", ctr_udbar, 1);
    chk("rst_ld", ctr_ld, 0);
    chk("rst_ldval", int'(ctr_ld_val), 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

    // reset in the third active cycle of UP 10
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen += int'(ctr_en);
    end
    chk("pre_rst_en", seen, 3);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_en", ctr_en, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      dn += int'(done) + int'(ctr_en);
    end
    chk("post_rst_quiet", dn, 0);

    // back-to-back UP 2 / DOWN 2 with valid held high
    v = '{2'd0, 8'd7, 2, 0, 1, 1, 0, 4'd7};
    run_cmd(v);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd2;
    @(posedge clk);
    #1 cmd_op = 2'd2;
    lat1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done && cmd_ready) begin
        lat1 = k;
        break;
      end
    end
    chk("b2b_first_done", lat1, 3);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat2 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk("b2b_second_start", int'(ctr_en & ~ctr_udbar), 1);
      if (done) begin
        lat2 = k;
        break;
      end
    end
    chk("b2b_second_done", lat2, 3);
    chk("b2b_cnt", int'(cnt), 7);

`ifdef SEQ_ABORT_EN
    v = '{2'd0, 8'd0, 2, 0, 1, 1, 0, 4'd0};
    run_cmd(v);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd200;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen < 5; k++) begin
      @(negedge clk);
      seen += int'(ctr_en);
    end
    chk("abort_active", seen, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_en", ctr_en, 0);
    chk("abort_done", done, 1);
    chk("abort_cnt", int'(cnt), 5);
    @(negedge clk);
    chk("abort_done_pulse", done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
